// File: rtl/ysyx_23060077_icache_refill_slave.sv
// Icache refill responder: turns a (addr, len) burst request into len+1
// consecutive word reads from a synchronous-read memory port and returns
// each word as a one-cycle data beat, flagging the final beat with r_last_o.
//
//  state | meaning
//  IDLE  | waiting for a request; latches addr/len on r_valid_i
//  WAIT  | WAIT_CYCLES idle cycles before each memory read
//  READ  | mem_en_o asserted for the current word address
//  CAPT  | memory data valid; registered beat issued on this edge
//  DONE  | one cycle after the last beat, swallows the still-high r_valid_i
module ysyx_23060077_icache_refill_slave #(
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  r_valid_i,
  input  logic [ADDR_WIDTH-1:0] r_addr_i,
  input  logic [LEN_WIDTH-1:0]  r_len_i,
  output logic                  r_ready_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic                  r_last_o,
  output logic                  mem_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_CAPT,
    S_DONE
  } state_e;

  localparam logic [3:0]            WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [3:0]            wait_q, wait_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ready_q, ready_d;
  logic                  last_q, last_d;

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic; ready/last default low so each beat is a single pulse.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    data_d  = data_q;
    ready_d = 1'b0;
    last_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (r_valid_i) begin
          addr_d = r_addr_i & WORD_MASK;
          len_d  = r_len_i;
          beat_d = '0;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            wait_d  = WAIT_INIT;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_WAIT: begin
        wait_d = wait_q - 4'd1;
        if (wait_q == 4'd1) state_d = S_READ;
      end
      S_READ: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        data_d  = mem_rdata_i;
        ready_d = 1'b1;
        last_d  = (beat_q == len_q);
        if (beat_q == len_q) begin
          state_d = S_DONE;
        end else begin
          // Compare happens before the increment, so len=all-ones never overflows.
          beat_d = beat_q + LEN_WIDTH'(1);
          addr_d = addr_q + WORD_STEP;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            wait_d  = WAIT_INIT;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_en_o   = (state_q == S_READ);
  assign mem_addr_o = addr_q;
  assign busy_o     = (state_q != S_IDLE);
  assign r_ready_o  = ready_q;
  assign r_last_o   = last_q;
  assign r_data_o   = data_q;

endmodule

// File: tb/tb_ysyx_23060077_icache_refill_slave.sv
// Bench for the Icache refill responder: two instances (no wait states and
// three wait states) each with a synchronous-read memory returning addr^A5A5A5A5.
module tb_ysyx_23060077_icache_refill_slave;

  logic        clock;
  logic        reset;
  logic        vld    [2];
  logic [31:0] adr    [2];
  logic [7:0]  len    [2];
  logic        rrdy   [2];
  logic [31:0] rdat_o [2];
  logic        rlst   [2];
  logic        men_o  [2];
  logic [31:0] maddr  [2];
  logic [31:0] mrd    [2];
  logic        bsy_o  [2];

  int checks = 0;
  int errors = 0;
  int cur_cyc = 0;
  logic [31:0] exp_data [2];

  ysyx_23060077_icache_refill_slave #(.WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .r_valid_i(vld[0]), .r_addr_i(adr[0]), .r_len_i(len[0]),
    .r_ready_o(rrdy[0]), .r_data_o(rdat_o[0]), .r_last_o(rlst[0]), .mem_en_o(men_o[0]),
    .mem_addr_o(maddr[0]), .mem_rdata_i(mrd[0]), .busy_o(bsy_o[0])
  );

  ysyx_23060077_icache_refill_slave #(.WAIT_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset), .r_valid_i(vld[1]), .r_addr_i(adr[1]), .r_len_i(len[1]),
    .r_ready_o(rrdy[1]), .r_data_o(rdat_o[1]), .r_last_o(rlst[1]), .mem_en_o(men_o[1]),
    .mem_addr_o(maddr[1]), .mem_rdata_i(mrd[1]), .busy_o(bsy_o[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) if (men_o[i]) mrd[i] <= memf(maddr[i]);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d: got %h expected %h", nm, cur_cyc, act, exp);
    end
  endtask

  // Timing derived from the burst rules: word k is read in cycle 1+W+(2+W)k
  // and returned in cycle 3+W+(2+W)k; busy spans cycles 1..last beat.
  function automatic void model(input int w, input int l, input logic [31:0] a, input int c,
                                output bit rdy, output bit lst, output bit men,
                                output logic [31:0] madr, output logic [31:0] rd, output bit bsy);
    int p;
    int lastc;
    int k;
    logic [31:0] base;
    p     = 2 + w;
    lastc = 3 + w + p * l;
    base  = a & 32'hFFFF_FFFC;
    bsy   = (c >= 1) && (c <= lastc);
    rdy = 0; lst = 0; men = 0; madr = '0; rd = '0;
    if (c >= 1 + w && (c - 1 - w) % p == 0 && (c - 1 - w) / p <= l) begin
      k    = (c - 1 - w) / p;
      men  = 1;
      madr = base + 32'(4 * k);
    end
    if (c >= 3 + w && (c - 3 - w) % p == 0 && (c - 3 - w) / p <= l) begin
      k   = (c - 3 - w) / p;
      rdy = 1;
      lst = (k == l);
      rd  = memf(base + 32'(4 * k));
    end
  endfunction

  // Called at a falling edge; that cycle is cycle 0 of the request.
  task automatic run_burst(input int sel, input logic [31:0] a, input int l, input bit hold,
                           input int stop_c, output int obs_last, output logic [31:0] obs_laddr,
                           output int obs_cnt);
    int w;
    int lastc;
    int endc;
    bit rdy, lst, men, bsy;
    logic [31:0] madr, rd;
    w     = (sel == 0) ? 0 : 3;
    lastc = 3 + w + (2 + w) * l;
    endc  = (stop_c > 0) ? stop_c : lastc + 1;
    vld[sel] = 1'b1;
    adr[sel] = a;
    len[sel] = 8'(l);
    obs_last = -1; obs_laddr = '0; obs_cnt = 0;
    for (int c = 1; c <= endc; c++) begin
      @(negedge clock);
      cur_cyc = c;
      model(w, l, a, c, rdy, lst, men, madr, rd, bsy);
      if (rdy) exp_data[sel] = rd;
      chk("r_ready_o", 32'(rrdy[sel]), 32'(rdy));
      chk("r_last_o", 32'(rlst[sel]), 32'(lst));
      chk("busy_o", 32'(bsy_o[sel]), 32'(bsy));
      chk("mem_en_o", 32'(men_o[sel]), 32'(men));
      chk("r_data_o", rdat_o[sel], exp_data[sel]);
      if (men) chk("mem_addr_o", maddr[sel], madr);
      if (rlst[sel]) obs_last = c;
      if (men_o[sel]) begin
        obs_cnt++;
        obs_laddr = maddr[sel];
      end
      if (c == 1 && !hold) begin
        vld[sel] = 1'b0;
        adr[sel] = $urandom;
        len[sel] = 8'($urandom);
      end
      if (hold && c == lastc + 1) vld[sel] = 1'b0;
    end
  endtask

  typedef struct {
    int          sel;
    logic [31:0] addr;
    int          len;
    bit          hold;
    int          exp_last;
    logic [31:0] exp_laddr;
    int          exp_cnt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int ol, oc;
    logic [31:0] oa;
    tbl[0] = '{0, 32'h3000_0000, 3,   1'b0, 9,   32'h3000_000C, 4};
    tbl[1] = '{0, 32'h3000_0006, 0,   1'b0, 3,   32'h3000_0004, 1};
    tbl[2] = '{1, 32'h3000_0000, 1,   1'b0, 11,  32'h3000_0004, 2};
    tbl[3] = '{0, 32'h8000_0010, 2,   1'b1, 7,   32'h8000_0018, 3};
    tbl[4] = '{0, 32'h1234_5678, 1,   1'b0, 5,   32'h1234_567C, 2};
    tbl[5] = '{0, 32'hFFFF_FFF8, 2,   1'b0, 7,   32'h0000_0000, 3};
    tbl[6] = '{1, 32'hFFFF_FFFC, 0,   1'b0, 6,   32'hFFFF_FFFC, 1};
    tbl[7] = '{0, 32'h0000_1000, 255, 1'b0, 513, 32'h0000_13FC, 256};

    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; adr[i] = '0; len[i] = '0; exp_data[i] = '0;
    end
    repeat (2) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk("reset r_ready_o", 32'(rrdy[i]), 32'd0);
      chk("reset r_last_o", 32'(rlst[i]), 32'd0);
      chk("reset busy_o", 32'(bsy_o[i]), 32'd0);
      chk("reset r_data_o", rdat_o[i], 32'd0);
    end
    reset = 1'b1;

    for (int t = 0; t < 8; t++) begin
      run_burst(tbl[t].sel, tbl[t].addr, tbl[t].len, tbl[t].hold, 0, ol, oa, oc);
      chk($sformatf("vec%0d last cycle", t), 32'(ol), 32'(tbl[t].exp_last));
      chk($sformatf("vec%0d last mem addr", t), oa, tbl[t].exp_laddr);
      chk($sformatf("vec%0d mem_en count", t), 32'(oc), 32'(tbl[t].exp_cnt));
    end

    // Asynchronous reset right after beat 1 of an 8-beat burst.
    run_burst(0, 32'h2000_0000, 7, 1'b0, 5, ol, oa, oc);
    #2 reset = 1'b0;
    #1;
    exp_data[0] = '0;
    exp_data[1] = '0;
    chk("async rst r_ready_o", 32'(rrdy[0]), 32'd0);
    chk("async rst r_last_o", 32'(rlst[0]), 32'd0);
    chk("async rst busy_o", 32'(bsy_o[0]), 32'd0);
    chk("async rst r_data_o", rdat_o[0], 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      chk("post rst r_ready_o", 32'(rrdy[0]), 32'd0);
      chk("post rst busy_o", 32'(bsy_o[0]), 32'd0);
      chk("post rst mem_en_o", 32'(men_o[0]), 32'd0);
    end
    run_burst(0, 32'h2000_0040, 1, 1'b0, 0, ol, oa, oc);
    chk("post rst last cycle", 32'(ol), 32'd5);
    chk("post rst mem_en count", 32'(oc), 32'd2);

    // Randomized bursts on both instances against the timing model.
    for (int r = 0; r < 24; r++) begin
      int sel, l, w;
      bit hold;
      logic [31:0] a;
      sel  = int'($urandom_range(0, 1));
      l    = int'($urandom_range(0, 6));
      hold = bit'($urandom_range(0, 1));
      a    = $urandom;
      w    = (sel == 0) ? 0 : 3;
      run_burst(sel, a, l, hold, 0, ol, oa, oc);
      chk("rand last cycle", 32'(ol), 32'(3 + w + (2 + w) * l));
      chk("rand mem_en count", 32'(oc), 32'(l + 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060077_icache_refill_slave.md
Name: ysyx_23060077_icache_refill_slave

Overview:
Responder end of the Icache refill read interface. It accepts a burst request (valid, addr, len) from the Icache, reads consecutive words from a synchronous-read instruction memory port, and returns them as single-cycle data beats. The final beat carries a last flag. The block sits between the Icache refill port and the instruction SRAM/flash model.

Parameters:
WAIT_CYCLES, 0, extra idle cycles inserted before every memory read (models slow memory); 0..15
ADDR_WIDTH, 32, request and memory address width
DATA_WIDTH, 32, beat and memory data width
LEN_WIDTH, 8, burst length field width (beats = len+1)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
r_valid_i  input  1  refill request valid from Icache
r_addr_i  input  ADDR_WIDTH  burst start byte address
r_len_i  input  LEN_WIDTH  burst length minus one
r_ready_o  output  1  beat strobe: r_data_o valid this cycle (1-cycle pulse per beat)
r_data_o  output  DATA_WIDTH  beat data
r_last_o  output  1  high with the final beat's r_ready_o only
mem_en_o  output  1  memory read enable
mem_addr_o  output  ADDR_WIDTH  word-aligned memory address
mem_rdata_i  input  DATA_WIDTH  memory data, valid the cycle after mem_en_o
busy_o  output  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-burst): state IDLE; r_ready_o=0, r_last_o=0, r_data_o=0, busy_o=0, beat counter=0, wait counter=0. The burst in progress is abandoned and no further beats are emitted.
- States: IDLE, WAIT, READ, CAPT, DONE.
- IDLE: when r_valid_i=1:
  - latch addr = r_addr_i with bits[1:0] forced to 0, latch len = r_len_i, beat=0;
  - next state is WAIT (wait counter = WAIT_CYCLES) if WAIT_CYCLES>0, else READ.
  - r_addr_i/r_len_i are ignored outside IDLE.
- WAIT: decrement the counter; go to READ when it reaches 1 (exactly WAIT_CYCLES cycles in WAIT).
- READ: mem_en_o=1, mem_addr_o=current addr (decoded from the state register, no input-to-output path). Next state CAPT.
- CAPT: at the clock edge:
  - r_data_o <= mem_rdata_i, r_ready_o <= 1, r_last_o <= (beat==len);
  - if beat==len, go to DONE;
  - else beat+1, addr+4, go to WAIT or READ.
- DONE: lasts one cycle, then IDLE. It absorbs the requester's r_valid_i, which is still high in the cycle r_last_o is seen, so the burst does not restart. The requester deasserts r_valid_i in the cycle after r_last_o.
- r_ready_o and r_last_o are registered one-cycle pulses. r_data_o holds its value between beats.
- No backpressure: the Icache always accepts a beat when r_ready_o=1.
- Latency with WAIT_CYCLES=0 and the request sampled in cycle 0:
  - mem_en_o in cycle 1; first r_ready_o in cycle 3;
  - subsequent beats every 2 cycles; beat k at cycle 3+2k;
  - general beat spacing is 2+WAIT_CYCLES.
- Total burst of len+1 beats: last beat at cycle 3+WAIT_CYCLES+(2+WAIT_CYCLES)*len; IDLE one cycle after the last beat.
- Address arithmetic is modulo 2^ADDR_WIDTH: 0xFFFF_FFFC + 4 wraps to 0x0000_0000. No burst-boundary wrap.
- len=0: a single beat with r_last_o=1. len=255: 256 beats; the 8-bit beat counter must not overflow before its compare.
- r_valid_i dropping mid-burst is ignored; the burst completes.

Test Plan:
- WAIT_CYCLES=0, addr=0x3000_0000, len=3, mem returns addr^0xA5A5_A5A5 -> four beats at cycles 3/5/7/9; mem_addr_o 0x3000_0000..0x3000_000C; r_last_o only at cycle 9; busy_o low at cycle 10.
- Unaligned addr=0x3000_0006, len=0 -> one read at 0x3000_0004; a single beat with r_ready_o=1 and r_last_o=1 at cycle 3.
- WAIT_CYCLES=3, len=1 -> beats at cycles 6 and 11; mem_en_o high exactly 2 cycles in total.
- r_valid_i held high through the cycle of r_last_o, then dropped -> no second burst started; a new request in the following IDLE cycle is accepted normally.
- reset pulled low asynchronously mid-burst (after beat 1 of len=7) -> r_ready_o, r_last_o and busy_o go 0 immediately; after release, no stray beats; a fresh len=1 request completes correctly.
- addr=0xFFFF_FFF8, len=2 -> mem_addr_o sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; r_last_o on the third beat.
